// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive front end and the transmitter.
// Holds the receiver state enum, the default frame/oversampling constants and
// the sample-counter width helper.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // Width of a counter that runs 0..os-1 (os is a power of two, >= 4).
  function automatic int unsigned cnt_width(input int unsigned os);
    return (os > 1) ? $clog2(os) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk_i  - destination clock, rising edge
//   rst_ni - asynchronous active-low reset, both flops load RESET_VAL
//   d_i    - asynchronous input
//   q_o    - synchronized output (second flop)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_oversampler.sv
// UART receive front end driven by an OVERSAMPLE x baud tick strobe.
// Finds the start bit, samples each data bit and the stop bit at mid-bit,
// and presents the received word with a one-cycle valid pulse.
// Ports:
//   clk         - system clock, rising edge
//   reset       - asynchronous active-low reset
//   tick        - one-clk strobe at OVERSAMPLE x baud; the FSM only advances on it
//   rx          - raw serial line, asynchronous, idle high
//   data_out    - last good word, held until the next good frame
//   data_valid  - one-clk pulse when data_out updates
//   frame_error - one-clk pulse when the stop bit samples low
//   busy        - high whenever the receiver is not idle
module uart_rx_oversampler
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = UART_DATA_BITS,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int unsigned CW = cnt_width(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_MID     = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_MAX     = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST_M1 = BW'(DATA_BITS - 1);

  logic rx_s;

  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q,   cnt_d;
  logic [BW-1:0]        bit_q,   bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q,  data_d;
  logic                 dv_q,    dv_d;
  logic                 fe_q,    fe_d;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk_i (clk),
    .rst_ni(reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
    end
  end

  // Pulses default low so they self-clear on the following clk edge even
  // when no tick arrives; everything else holds between ticks.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;

    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            cnt_d   = '0;
          end
        end

        START: begin
          if (cnt_q == CNT_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              cnt_d   = '0;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (cnt_q == CNT_MAX) begin
            // LSB arrives first, so shifting right leaves it at bit 0.
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            cnt_d   = '0;
            bit_d   = bit_q + 1'b1;
            if (bit_q == BIT_LAST_M1) begin
              state_d = STOP;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        STOP: begin
          if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            if (rx_s) begin
              data_d  = shift_q;
              dv_d    = 1'b1;
              state_d = IDLE;
            end else begin
              fe_d    = 1'b1;
              state_d = WAIT_HIGH;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        WAIT_HIGH: begin
          // A line stuck low must return high before a new start is accepted.
          if (rx_s) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign data_out    = data_q;
  assign data_valid  = dv_q;
  assign frame_error = fe_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampler.sv
module tb_uart_rx_oversampler;

  localparam int DB       = 8;
  localparam int OS       = 16;
  localparam int STOP_OFS = OS / 2 + OS * (DB + 1);

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          tick  = 1'b0;
  logic          rx    = 1'b1;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          frame_error;
  logic          busy;

  uart_rx_oversampler #(
    .DATA_BITS (DB),
    .OVERSAMPLE(OS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- tick source: fixed every 4 clks, or random gaps 1..7 ----
  int tick_mode = 0;
  initial begin
    int gap;
    gap = 4;
    forever begin
      @(posedge clk);
      #1;
      gap--;
      if (gap == 0) begin
        tick = 1'b1;
        gap  = (tick_mode != 0) ? int'($urandom_range(7, 1)) : 4;
      end else begin
        tick = 1'b0;
      end
    end
  end

  // ---------------- reference model -----------------------------------------
  // The receiver sees the line two clk edges late. Every tick records what the
  // receiver sees; frames are decoded by tick offset from the first low tick.
  bit            samp[$];
  logic          ln1 = 1'b1, ln2 = 1'b1;
  int            mode = 0;          // 0 idle, 1 inside frame, 2 waiting for high line
  int            k0 = 0;
  int            tick_no = 0;
  int            busy_ticks = 0;
  logic          busy_neg = 1'b0;
  logic [DB-1:0] exp_data = '0;
  logic          exp_dv = 1'b0, exp_fe = 1'b0, exp_busy = 1'b0;

  function automatic logic [DB-1:0] frame_byte(input int start);
    logic [DB-1:0] b;
    for (int i = 0; i < DB; i++) b[i] = samp[start + OS / 2 + OS * (i + 1)];
    return b;
  endfunction

  initial begin
    logic s;
    int   d;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        ln1 = 1'b1; ln2 = 1'b1;
        samp.delete();
        mode = 0;
        exp_data = '0; exp_dv = 1'b0; exp_fe = 1'b0; exp_busy = 1'b0;
      end else begin
        s   = ln2;
        ln2 = ln1;
        ln1 = rx;
        exp_dv = 1'b0;
        exp_fe = 1'b0;
        if (tick) begin
          tick_no++;
          if (busy_neg) busy_ticks++;
          samp.push_back(s);
          if (mode == 0) begin
            if (!s) begin
              mode = 1;
              k0   = samp.size() - 1;
            end
          end else if (mode == 1) begin
            d = samp.size() - 1 - k0;
            if (d == OS / 2 && s) begin
              mode = 0;
            end else if (d == STOP_OFS) begin
              if (s) begin
                exp_data = frame_byte(k0);
                exp_dv   = 1'b1;
                mode     = 0;
              end else begin
                exp_fe = 1'b1;
                mode   = 2;
              end
            end
          end else if (s) begin
            mode = 0;
          end
          exp_busy = (mode != 0);
        end
      end
    end
  end

  // ---------------- per-cycle compare + event log ----------------------------
  int            dv_cnt = 0, fe_cnt = 0;
  logic [DB-1:0] dv_data[$];
  int            dv_tick[$];
  logic [DB-1:0] fe_data = '0;

  initial begin
    forever begin
      @(negedge clk);
      busy_neg = busy;
      check("data_valid", 32'(data_valid), 32'(exp_dv));
      check("frame_error", 32'(frame_error), 32'(exp_fe));
      check("busy", 32'(busy), 32'(exp_busy));
      check("data_out", 32'(data_out), 32'(exp_data));
      if (data_valid && frame_error) check("pulse_exclusive", 32'd1, 32'd0);
      if (data_valid) begin
        dv_cnt++;
        dv_data.push_back(data_out);
        dv_tick.push_back(tick_no);
      end
      if (frame_error) begin
        fe_cnt++;
        fe_data = data_out;
      end
    end
  end

  // ---------------- stimulus -------------------------------------------------
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (tick !== 1'b1);
    end
    #1;
  endtask

  task automatic send_frame(input logic [DB-1:0] b, input logic stop_v);
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < DB; i++) begin
      rx = b[i];
      wait_ticks(OS);
    end
    rx = stop_v;
    wait_ticks(OS);
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  initial begin
    #900us;
    failures++;
    $display("FAIL watchdog run did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int            n0, f0, b0;
    logic [DB-1:0] v;
    logic          st;
    logic [DB-1:0] b55;

    #2 reset = 1'b0;
    #1;
    check("reset_data_out", 32'(data_out), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_pulses", 32'({data_valid, frame_error}), 32'd0);
    #20 reset = 1'b1;
    wait_ticks(4);

    // 0xA5, regular ticks
    n0 = dv_cnt; f0 = fe_cnt; b0 = busy_ticks;
    send_frame(8'hA5, 1'b1);
    wait_ticks(10);
    check("a5_valid_count", 32'(dv_cnt - n0), 32'd1);
    check("a5_no_frame_error", 32'(fe_cnt - f0), 32'd0);
    check("a5_data", 32'(data_out), 32'h0000_00A5);
    check("a5_busy_ticks", 32'(busy_ticks - b0), 32'd152);

    // back-to-back 0x00, 0xFF
    n0 = dv_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_ticks(10);
    check("b2b_count", 32'(dv_cnt - n0), 32'd2);
    if (dv_cnt - n0 == 2) begin
      check("b2b_first", 32'(dv_data[n0]), 32'h0000_0000);
      check("b2b_second", 32'(dv_data[n0 + 1]), 32'h0000_00FF);
      check("b2b_spacing", 32'(dv_tick[n0 + 1] - dv_tick[n0]), 32'd160);
    end

    // glitch: low for 3 ticks
    n0 = dv_cnt; f0 = fe_cnt;
    rx = 1'b0;
    wait_ticks(3);
    rx = 1'b1;
    wait_ticks(20);
    check("glitch_no_valid", 32'(dv_cnt - n0), 32'd0);
    check("glitch_no_ferr", 32'(fe_cnt - f0), 32'd0);
    check("glitch_idle", 32'(busy), 32'd0);

    // bad stop bit, line held low, then a good 0x81
    n0 = dv_cnt; f0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    wait_ticks(40);
    check("break_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    wait_ticks(20);
    check("break_ferr_count", 32'(fe_cnt - f0), 32'd1);
    check("break_data_held", 32'(fe_data), 32'h0000_00FF);
    check("break_no_valid", 32'(dv_cnt - n0), 32'd0);
    send_frame(8'h81, 1'b1);
    wait_ticks(5);
    check("after_break_count", 32'(dv_cnt - n0), 32'd1);
    check("after_break_data", 32'(data_out), 32'h0000_0081);

    // reset during data bit 4 of 0x55
    n0 = dv_cnt;
    b55 = 8'h55;
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      rx = b55[i];
      wait_ticks(OS);
    end
    rx = b55[4];
    wait_ticks(8);
    check("mid_frame_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_data_out", 32'(data_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pulses", 32'({data_valid, frame_error}), 32'd0);
    #2 reset = 1'b1;
    rx = 1'b1;
    wait_ticks(20);
    send_frame(8'h55, 1'b1);
    wait_ticks(5);
    check("after_reset_count", 32'(dv_cnt - n0), 32'd1);
    check("after_reset_data", 32'(data_out), 32'h0000_0055);

    // irregular tick spacing
    tick_mode = 1;
    wait_ticks(5);
    n0 = dv_cnt;
    send_frame(8'hC3, 1'b1);
    wait_ticks(5);
    check("irregular_count", 32'(dv_cnt - n0), 32'd1);
    check("irregular_data", 32'(data_out), 32'h0000_00C3);

    // random frames, gaps, tick modes and occasional bad stop bits
    for (int f = 0; f < 10; f++) begin
      tick_mode = int'($urandom_range(1, 0));
      v  = DB'($urandom);
      st = ($urandom_range(5, 0) != 0);
      send_frame(v, st);
      if (!st) begin
        wait_ticks(int'($urandom_range(20, 0)));
        rx = 1'b1;
      end
      wait_ticks(int'($urandom_range(10, 0)));
    end
    wait_ticks(30);

    finish_run();
  end

endmodule
